// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID handshake, external control decode, writeback and ID/EX bundle signals
interface id_stage_if #(
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [0:31]       if_instr;
    logic [0:31]       if_pc;
    logic [0:31]       id_instr;
    logic              ctrl_reg_dst;
    logic              ctrl_reg_wr;
    logic              ctrl_alu_src;
    logic              ctrl_ext_op;
    logic              ctrl_imm_zero;
    logic              ctrl_mem_rd;
    logic              ctrl_uses_rt;
    logic              ctrl_jal;
    logic              wb_wr;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_operand_a;
    logic [DATA_W-1:0] ex_operand_b;
    logic [DATA_W-1:0] ex_store_data;
    logic [4:0]        ex_dst;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic [0:31]       ex_pc;

    modport master (
        output if_valid, if_instr, if_pc,
        output ctrl_reg_dst, ctrl_reg_wr, ctrl_alu_src, ctrl_ext_op,
        output ctrl_imm_zero, ctrl_mem_rd, ctrl_uses_rt, ctrl_jal,
        output wb_wr, wb_addr, wb_data, flush, ex_ready,
        input  if_ready, id_instr, ex_valid, ex_operand_a, ex_operand_b,
        input  ex_store_data, ex_dst, ex_reg_wr, ex_mem_rd, ex_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc,
        input  ctrl_reg_dst, ctrl_reg_wr, ctrl_alu_src, ctrl_ext_op,
        input  ctrl_imm_zero, ctrl_mem_rd, ctrl_uses_rt, ctrl_jal,
        input  wb_wr, wb_addr, wb_data, flush, ex_ready,
        output if_ready, id_instr, ex_valid, ex_operand_a, ex_operand_b,
        output ex_store_data, ex_dst, ex_reg_wr, ex_mem_rd, ex_pc
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined decode stage with GPR file, immediate build and load-use stall
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int LINK_REG = 31
) (
    input logic       clk_i,
    input logic       reset_i,
    id_stage_if.slave bus
);
    localparam logic [4:0] LINK = 5'(LINK_REG);
    localparam bit         ZR   = ZERO_REG != 0;

    logic [DATA_W-1:0] gpr_q [32];
    logic              id_valid_q, id_valid_d;
    logic [0:31]       id_instr_q, id_instr_d;
    logic [0:31]       id_pc_q, id_pc_d;
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [DATA_W-1:0] ex_sd_q, ex_sd_d;
    logic [4:0]        ex_dst_q, ex_dst_d;
    logic              ex_reg_wr_q, ex_reg_wr_d;
    logic              ex_mem_rd_q, ex_mem_rd_d;
    logic [0:31]       ex_pc_q, ex_pc_d;
    logic [4:0]        rs, rt, rd, dst;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
    logic              hazard, ex_free, advance, ready, accept, load;

    // Instruction fields of the word held in ID (bit 0 is the MSB)
    assign rs  = id_instr_q[6:10];
    assign rt  = id_instr_q[11:15];
    assign rd  = id_instr_q[16:20];
    assign imm = bus.ctrl_imm_zero ? 16'h0 : id_instr_q[16:31];
    assign imm_ext = bus.ctrl_ext_op ? DATA_W'($signed(imm)) : DATA_W'(imm);
    assign dst = bus.ctrl_jal ? LINK : bus.ctrl_reg_dst ? rd : rt;

    // Write-through read: a same-cycle writeback is visible, r0 stays zero even when bypassed
    assign rs_val = (ZR && rs == 5'd0) ? '0 :
                    (bus.wb_wr && bus.wb_addr == rs) ? bus.wb_data : gpr_q[rs];
    assign rt_val = (ZR && rt == 5'd0) ? '0 :
                    (bus.wb_wr && bus.wb_addr == rt) ? bus.wb_data : gpr_q[rt];

    // A load in EX whose result the ID instruction needs holds ID back for one bubble
    assign hazard  = id_valid_q & ex_valid_q & ex_mem_rd_q & ex_reg_wr_q & (ex_dst_q != 5'd0) &
                     ((ex_dst_q == rs) | (bus.ctrl_uses_rt & (ex_dst_q == rt)));
    assign ex_free = !ex_valid_q | bus.ex_ready;
    assign advance = id_valid_q & !hazard & ex_free;
    assign ready   = !bus.flush & (!id_valid_q | advance);
    assign accept  = bus.if_valid & ready;
    assign load    = advance & !bus.flush;

    // ID register next state: flush kills, new fetch loads, advancing empties, otherwise hold
    always_comb begin
        id_valid_d = bus.flush ? 1'b0 : accept ? 1'b1 : advance ? 1'b0 : id_valid_q;
        id_instr_d = accept ? bus.if_instr : id_instr_q;
        id_pc_d    = accept ? bus.if_pc : id_pc_q;
    end

    // EX register next state: flush kills, advance loads, free slot bubbles, stalled bundle holds
    always_comb begin
        ex_valid_d  = bus.flush ? 1'b0 : advance ? 1'b1 : ex_free ? 1'b0 : ex_valid_q;
        ex_a_d      = load ? rs_val : ex_a_q;
        ex_b_d      = load ? (bus.ctrl_alu_src ? imm_ext : rt_val) : ex_b_q;
        ex_sd_d     = load ? rt_val : ex_sd_q;
        ex_dst_d    = load ? dst : ex_dst_q;
        ex_reg_wr_d = load ? bus.ctrl_reg_wr : ex_reg_wr_q;
        ex_mem_rd_d = load ? bus.ctrl_mem_rd : ex_mem_rd_q;
        ex_pc_d     = load ? id_pc_q : ex_pc_q;
    end

    // Pipeline registers with synchronous clear
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_sd_q     <= '0;
            ex_dst_q    <= '0;
            ex_reg_wr_q <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_pc_q     <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            ex_valid_q  <= ex_valid_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_sd_q     <= ex_sd_d;
            ex_dst_q    <= ex_dst_d;
            ex_reg_wr_q <= ex_reg_wr_d;
            ex_mem_rd_q <= ex_mem_rd_d;
            ex_pc_q     <= ex_pc_d;
        end
    end

    // GPR file: cleared on reset, writeback continues through flush, r0 writes dropped
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
        end else if (bus.wb_wr && !(ZR && bus.wb_addr == 5'd0)) begin
            gpr_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.if_ready      = ready;
    assign bus.id_instr      = id_instr_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_operand_a  = ex_a_q;
    assign bus.ex_operand_b  = ex_b_q;
    assign bus.ex_store_data = ex_sd_q;
    assign bus.ex_dst        = ex_dst_q;
    assign bus.ex_reg_wr     = ex_reg_wr_q;
    assign bus.ex_mem_rd     = ex_mem_rd_q;
    assign bus.ex_pc         = ex_pc_q;
endmodule
